// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    HALT   = 4'd11
  } stateT;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_SLT = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SRA = 4'd6,
    ALU_OR  = 4'd7,
    ALU_AND = 4'd8
  } aluOpT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  // Next-PC select
  localparam logic [1:0] PC4   = 2'd0;
  localparam logic [1:0] PCIMM = 2'd1;

  // Register-file write-data select
  localparam logic [1:0] ORIG_ALU = 2'd0;
  localparam logic [1:0] ORIG_MEM = 2'd1;
  localparam logic [1:0] ORIG_PC4 = 2'd2;

  // ALU second-operand select
  localparam logic ORIG_REG = 1'b0;
  localparam logic ORIG_IMM = 1'b1;

  function automatic logic isStore(input logic [6:0] opcode);
    return opcode == OP_STORE;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle. master = control unit, slave = datapath side.
interface multicycle_control_if;
  logic [31:0] iInstruction;
  logic        iEqual;
  logic        iMemReady;
  logic        oIRWrite;
  logic        oPCWrite;
  logic        oMemRead;
  logic        oMemWrite;
  logic        oRegWrite;
  logic        oOrigALU;
  logic [1:0]  oOrigPC;
  logic [1:0]  oOrigWriteData;
  logic [3:0]  oALUControl;
  logic [3:0]  oState;
  logic        oRetire;
  logic        oHalted;

  modport master (
    input  iInstruction, iEqual, iMemReady,
    output oIRWrite, oPCWrite, oMemRead, oMemWrite, oRegWrite, oOrigALU,
           oOrigPC, oOrigWriteData, oALUControl, oState, oRetire, oHalted
  );

  modport slave (
    output iInstruction, iEqual, iMemReady,
    input  oIRWrite, oPCWrite, oMemRead, oMemWrite, oRegWrite, oOrigALU,
           oOrigPC, oOrigWriteData, oALUControl, oState, oRetire, oHalted
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from funct3 / instruction bit 30.
// Bit 30 selects SUB only for R-type; it selects SRA for both shift forms.
import multicycle_control_pkg::*;

module alu_decoder (
  input  logic [2:0] funct3,
  input  logic       bit30,
  input  logic       isRType,
  output aluOpT      aluOp
);

  // Pure decode table
  always_comb begin
    aluOp = ALU_ADD;
    case (funct3)
      3'b000:  aluOp = (isRType && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  aluOp = ALU_SLL;
      3'b010:  aluOp = ALU_SLT;
      3'b100:  aluOp = ALU_XOR;
      3'b101:  aluOp = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  aluOp = ALU_OR;
      3'b111:  aluOp = ALU_AND;
      default: aluOp = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control unit (Moore FSM).
// Optional: define RV_PERF_CNT_EN to add oCycleCount / oRetireCount.
import multicycle_control_pkg::*;

module multicycle_control (
  input logic clock,
  input logic reset,
  multicycle_control_if.master bus
`ifdef RV_PERF_CNT_EN
  ,
  output logic [31:0] oCycleCount,
  output logic [31:0] oRetireCount
`endif
);

  stateT       state;
  stateT       stateNext;
  aluOpT       decodedOp;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        irWrite;
  logic        pcWrite;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic        origALU;
  logic [1:0]  origPC;
  logic [1:0]  origWriteData;
  aluOpT       aluControl;
  logic        halted;
  logic        unusedBits;

  assign opcode     = bus.iInstruction[6:0];
  assign funct3     = bus.iInstruction[14:12];
  assign unusedBits = ^{bus.iInstruction[31], bus.iInstruction[29:15],
                        bus.iInstruction[11:7]};

  alu_decoder uAluDecoder (
    .funct3  (funct3),
    .bit30   (bus.iInstruction[30]),
    .isRType (opcode == OP_R),
    .aluOp   (decodedOp)
  );

  // State register; reset wins over every transition
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= stateNext;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    stateNext     = state;
    irWrite       = 1'b0;
    pcWrite       = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    regWrite      = 1'b0;
    origALU       = ORIG_REG;
    origPC        = PC4;
    origWriteData = ORIG_ALU;
    aluControl    = ALU_ADD;
    halted        = 1'b0;
    case (state)
      FETCH: begin
        irWrite   = 1'b1;
        stateNext = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:               stateNext = EXEC_R;
          OP_I:               stateNext = EXEC_I;
          OP_LOAD, OP_STORE:  stateNext = ADDR;
          OP_BRANCH:          stateNext = (funct3 == F3_BEQ) ? BRANCH : HALT;
          OP_JAL:             stateNext = JAL;
          default:            stateNext = HALT;
        endcase
      end
      EXEC_R: begin
        origALU    = ORIG_REG;
        aluControl = decodedOp;
        stateNext  = WB_ALU;
      end
      EXEC_I: begin
        origALU    = ORIG_IMM;
        aluControl = decodedOp;
        stateNext  = WB_ALU;
      end
      ADDR: begin
        origALU    = ORIG_IMM;
        aluControl = ALU_ADD;
        stateNext  = isStore(opcode) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        memRead    = 1'b1;
        origALU    = ORIG_IMM;
        aluControl = ALU_ADD;
        if (bus.iMemReady) stateNext = WB_MEM;
      end
      MEM_WR: begin
        memWrite   = 1'b1;
        origALU    = ORIG_IMM;
        aluControl = ALU_ADD;
        if (bus.iMemReady) begin
          pcWrite   = 1'b1;
          origPC    = PC4;
          stateNext = FETCH;
        end
      end
      WB_ALU: begin
        regWrite      = 1'b1;
        origWriteData = ORIG_ALU;
        pcWrite       = 1'b1;
        origPC        = PC4;
        stateNext     = FETCH;
      end
      WB_MEM: begin
        regWrite      = 1'b1;
        origWriteData = ORIG_MEM;
        pcWrite       = 1'b1;
        origPC        = PC4;
        stateNext     = FETCH;
      end
      BRANCH: begin
        pcWrite   = 1'b1;
        origPC    = bus.iEqual ? PCIMM : PC4;
        stateNext = FETCH;
      end
      JAL: begin
        regWrite      = 1'b1;
        origWriteData = ORIG_PC4;
        pcWrite       = 1'b1;
        origPC        = PCIMM;
        stateNext     = FETCH;
      end
      HALT: begin
        halted    = 1'b1;
        stateNext = HALT;
      end
      default: stateNext = FETCH;
    endcase
  end

  // Outputs forced to their idle values while reset is held, so a reset
  // arriving mid-wait cannot complete a memory access or retire.
  assign bus.oIRWrite       = irWrite  & ~reset;
  assign bus.oPCWrite       = pcWrite  & ~reset;
  assign bus.oMemRead       = memRead  & ~reset;
  assign bus.oMemWrite      = memWrite & ~reset;
  assign bus.oRegWrite      = regWrite & ~reset;
  assign bus.oOrigALU       = reset ? ORIG_REG : origALU;
  assign bus.oOrigPC        = reset ? PC4 : origPC;
  assign bus.oOrigWriteData = reset ? ORIG_ALU : origWriteData;
  assign bus.oALUControl    = reset ? ALU_ADD : aluControl;
  assign bus.oState         = reset ? FETCH : state;
  assign bus.oRetire        = pcWrite & ~reset;
  assign bus.oHalted        = halted & ~reset;

`ifdef RV_PERF_CNT_EN
  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clock) begin
    if (reset) begin
      oCycleCount  <= '0;
      oRetireCount <= '0;
    end else begin
      oCycleCount  <= oCycleCount + 32'd1;
      oRetireCount <= oRetireCount + {31'd0, pcWrite};
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Each cycle all outputs are
// packed into one 20-bit word and compared against a hand-built expectation:
// {state[3:0], irW, pcW, memRd, memWr, regW, origALU, origPC[1:0],
//  origWD[1:0], aluCtl[3:0], retire, halted}
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  multicycle_control_if bus();

`ifdef RV_PERF_CNT_EN
  logic [31:0] cycleCount;
  logic [31:0] retireCount;
`endif

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef RV_PERF_CNT_EN
    ,
    .oCycleCount  (cycleCount),
    .oRetireCount (retireCount)
`endif
  );

  always #5 clock = ~clock;

  logic [19:0] obs;
  assign obs = {bus.oState, bus.oIRWrite, bus.oPCWrite, bus.oMemRead,
                bus.oMemWrite, bus.oRegWrite, bus.oOrigALU, bus.oOrigPC,
                bus.oOrigWriteData, bus.oALUControl, bus.oRetire, bus.oHalted};

  function automatic logic [19:0] pk(input int st, input bit ir, input bit pcw,
                                     input bit mr, input bit mw, input bit rw,
                                     input bit oa, input int opc, input int owd,
                                     input int alu, input bit ret, input bit hlt);
    logic [3:0] s4, a4;
    logic [1:0] p2, w2;
    s4 = st[3:0]; a4 = alu[3:0]; p2 = opc[1:0]; w2 = owd[1:0];
    return {s4, ir, pcw, mr, mw, rw, oa, p2, w2, a4, ret, hlt};
  endfunction

  // Expected words for the two states every instruction shares
  logic [19:0] expFetch, expDecode;
  initial begin
    expFetch  = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expDecode = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.iInstruction = 32'h0000_0000;
    bus.iEqual = 1'b0;
    bus.iMemReady = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    compared++;
    if (obs !== 20'h00000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %05h want %05h", obs, 20'h00000);
    end
`ifdef RV_PERF_CNT_EN
    compared++;
    if (cycleCount !== 32'd0 || retireCount !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", cycleCount, retireCount);
    end
`endif
    reset = 1'b0;
    #1;
    compared++;
    if (obs !== expFetch) begin
      mismatched++;
      $display("FAIL reset_release_fetch: got %05h want %05h", obs, expFetch);
    end
  endtask

  // One R/I-type ALU instruction: FETCH, DECODE, EXEC_x, WB_ALU (4 cycles)
  task automatic run_alu(input string name, input logic [31:0] instr,
                         input bit isR, input int alu);
    logic [19:0] ex[$];
    ex = '{expFetch, expDecode,
           pk(isR ? 2 : 3, 0, 0, 0, 0, 0, isR ? 0 : 1, 0, 0, alu, 0, 0),
           pk(7, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0)};
    bus.iInstruction = instr;
    for (int k = 0; k < ex.size(); k++) begin
      #1;
      compared++;
      if (obs !== ex[k]) begin
        mismatched++;
        $display("FAIL %s cycle %0d: got %05h want %05h", name, k, obs, ex[k]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_alu();
    run_alu("add_r",     32'h002081B3, 1'b1, 0);  // add  x3,x1,x2
    run_alu("sub_r",     32'h402081B3, 1'b1, 1);  // sub  x3,x1,x2
    run_alu("slt_r",     32'h0020A1B3, 1'b1, 3);  // slt  x3,x1,x2
    run_alu("addi_b30",  32'h40000093, 1'b0, 0);  // addi x1,x0,0x400 (bit30 set, still ADD)
    run_alu("srai_i",    32'h40315093, 1'b0, 6);  // srai x1,x2,3
    run_alu("andi_i",    32'h00007093, 1'b0, 8);  // andi x1,x0,0
  endtask

  // lw with three wait cycles: MEM_RD held 4 cycles, 8 cycles total
  task automatic test_load();
    logic [19:0] ex[$];
    bit rdy[$];
    ex = '{expFetch, expDecode,
           pk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(8, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0)};
    rdy = '{0, 0, 0, 0, 0, 0, 1, 0};
    bus.iInstruction = 32'h0000A283;               // lw x5,0(x1)
    for (int k = 0; k < ex.size(); k++) begin
      bus.iMemReady = rdy[k];
      #1;
      compared++;
      if (obs !== ex[k]) begin
        mismatched++;
        $display("FAIL load_wait cycle %0d: got %05h want %05h", k, obs, ex[k]);
      end
      @(negedge clock);
    end
    bus.iMemReady = 1'b0;
  endtask

  // sw with two wait cycles: retires from MEM_WR, 6 cycles total
  task automatic test_store();
    logic [19:0] ex[$];
    bit rdy[$];
    ex = '{expFetch, expDecode,
           pk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0),
           pk(6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0),
           pk(6, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0)};
    rdy = '{0, 0, 0, 0, 0, 1};
    bus.iInstruction = 32'h0020A023;               // sw x2,0(x1)
    for (int k = 0; k < ex.size(); k++) begin
      bus.iMemReady = rdy[k];
      #1;
      compared++;
      if (obs !== ex[k]) begin
        mismatched++;
        $display("FAIL store_wait cycle %0d: got %05h want %05h", k, obs, ex[k]);
      end
      @(negedge clock);
    end
    bus.iMemReady = 1'b0;
  endtask

  task automatic test_branch();
    for (int pass = 0; pass < 2; pass++) begin
      logic [19:0] ex[$];
      ex = '{expFetch, expDecode,
             pk(9, 0, 1, 0, 0, 0, 0, (pass == 0) ? 1 : 0, 0, 0, 1, 0)};
      bus.iInstruction = 32'h00208063;             // beq x1,x2,0
      bus.iEqual = (pass == 0);
      for (int k = 0; k < ex.size(); k++) begin
        #1;
        compared++;
        if (obs !== ex[k]) begin
          mismatched++;
          $display("FAIL beq_eq%0d cycle %0d: got %05h want %05h", 1 - pass, k, obs, ex[k]);
        end
        @(negedge clock);
      end
    end
    bus.iEqual = 1'b0;
  endtask

  task automatic test_jal();
    logic [19:0] ex[$];
    ex = '{expFetch, expDecode, pk(10, 0, 1, 0, 0, 1, 0, 1, 2, 0, 1, 0)};
    bus.iInstruction = 32'h008000EF;               // jal x1,8
    for (int k = 0; k < ex.size(); k++) begin
      #1;
      compared++;
      if (obs !== ex[k]) begin
        mismatched++;
        $display("FAIL jal cycle %0d: got %05h want %05h", k, obs, ex[k]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_halt();
    logic [19:0] ex[$];
    ex = '{expFetch, expDecode};
    for (int k = 0; k < 10; k++) ex.push_back(pk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    bus.iInstruction = 32'h00000073;               // opcode 1110011
    for (int k = 0; k < ex.size(); k++) begin
      #1;
      compared++;
      if (obs !== ex[k]) begin
        mismatched++;
        $display("FAIL halt cycle %0d: got %05h want %05h", k, obs, ex[k]);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (obs !== 20'h00000) begin
      mismatched++;
      $display("FAIL halt_reset_held: got %05h want %05h", obs, 20'h00000);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    compared++;
    if (obs !== expFetch) begin
      mismatched++;
      $display("FAIL halt_reset_fetch: got %05h want %05h", obs, expFetch);
    end
  endtask

  // Reset arriving while MEM_WR waits, with iMemReady rising in the same cycle
  task automatic test_reset_mid_wait();
    logic [19:0] ex[$];
    ex = '{expFetch, expDecode,
           pk(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
           pk(6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
    bus.iInstruction = 32'h0020A023;               // sw x2,0(x1)
    bus.iMemReady = 1'b0;
    for (int k = 0; k < ex.size(); k++) begin
      #1;
      compared++;
      if (obs !== ex[k]) begin
        mismatched++;
        $display("FAIL midwait_pre cycle %0d: got %05h want %05h", k, obs, ex[k]);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    bus.iMemReady = 1'b1;
    #1;
    compared++;
    if (obs !== 20'h00000) begin
      mismatched++;
      $display("FAIL midwait_reset_outputs: got %05h want %05h", obs, 20'h00000);
    end
    @(negedge clock);
    #1;
`ifdef RV_PERF_CNT_EN
    compared++;
    if (cycleCount !== 32'd0 || retireCount !== 32'd0) begin
      mismatched++;
      $display("FAIL midwait_counters: got %0d/%0d want 0/0", cycleCount, retireCount);
    end
`endif
    bus.iMemReady = 1'b0;
    reset = 1'b0;
    #1;
    compared++;
    if (obs !== expFetch) begin
      mismatched++;
      $display("FAIL midwait_fetch: got %05h want %05h", obs, expFetch);
    end
`ifdef RV_PERF_CNT_EN
    bus.iInstruction = 32'h008000EF;               // jal: 3 cycles, 1 retire
    repeat (3) @(negedge clock);
    #1;
    compared++;
    if (cycleCount !== 32'd3 || retireCount !== 32'd1) begin
      mismatched++;
      $display("FAIL counters_after_jal: got %0d/%0d want 3/1", cycleCount, retireCount);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_halt();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clock, input, 1, rising-edge system clock.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port iInstruction, input, 32, current instruction register contents.
REQ-004 SHALL have port iEqual, input, 1, registerRead1 == registerRead2 from the datapath.
REQ-005 SHALL have port iMemReady, input, 1, data memory done (read data valid or write accepted).
REQ-006 SHALL have ports oIRWrite, oPCWrite, oMemRead, oMemWrite, oRegWrite, oOrigALU, each output, 1, datapath enables.
REQ-007 SHALL have ports oOrigPC (2), oOrigWriteData (2) and oALUControl (4), outputs, with encodings as in the shared package.
REQ-008 SHALL have ports oState (4), oRetire (1, one-cycle pulse per completed instruction) and oHalted (1), outputs.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, HALT.
REQ-010 In FETCH it SHALL assert oIRWrite and go to DECODE.
REQ-011 In DECODE it SHALL dispatch on iInstruction[6:0]: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->ADDR, 1100011 with funct3=000->BRANCH, 1101111->JAL, any other value->HALT.
REQ-012 EXEC_R SHALL drive oOrigALU=ORIG_REG; EXEC_I SHALL drive oOrigALU=ORIG_IMM; both SHALL go to WB_ALU.
REQ-013 ALU op SHALL be decoded from funct3 and iInstruction[30]: add/sub (sub only for R-type with bit30=1), sll, slt, xor, srl/sra, or, and.
REQ-014 ADDR SHALL drive ALU_ADD with ORIG_IMM and go to MEM_RD for loads or MEM_WR for stores.
REQ-015 MEM_RD and MEM_WR SHALL hold oMemRead/oMemWrite and the address controls high, staying in state while iMemReady=0, for an unbounded number of cycles.
REQ-016 MEM_RD SHALL go to WB_MEM on iMemReady=1; MEM_WR SHALL go to FETCH on iMemReady=1, asserting oPCWrite with PC4 in that cycle.
REQ-017 WB_ALU SHALL assert oRegWrite with ORIG_ALU; WB_MEM SHALL assert oRegWrite with ORIG_MEM; each SHALL assert oPCWrite with PC4 and return to FETCH.
REQ-018 BRANCH SHALL assert oPCWrite with PCIMM when iEqual=1, else with PC4, and return to FETCH.
REQ-019 JAL SHALL assert oRegWrite with ORIG_PC4 and oPCWrite with PCIMM in the same cycle, then return to FETCH.
REQ-020 oPCWrite SHALL be asserted exactly once per instruction, in its final state; oRetire SHALL equal that assertion.
REQ-021 Latencies from FETCH to FETCH SHALL be: ALU 4, store 4+w, load 5+w (w = wait cycles), branch 3, jal 3.
REQ-022 HALT SHALL deassert all enables, drive oHalted=1, and remain in HALT until reset.
REQ-023 All enable outputs SHALL be 0 in any state not listed as asserting them; oALUControl SHALL default to ALU_ADD.

Reset
REQ-024 reset SHALL move the FSM to FETCH on the next edge, with priority over every transition, including mid-wait in MEM_RD/MEM_WR and in HALT.
REQ-025 During reset all enables SHALL be 0, with oHalted=0, oRetire=0 and oState=FETCH encoding 0.

Configuration
REQ-026 With RV_PERF_CNT_EN defined, the block SHALL add 32-bit outputs oCycleCount and oRetireCount.
REQ-027 oCycleCount SHALL increment every non-reset cycle; oRetireCount SHALL increment on oRetire; both SHALL clear on reset and wrap modulo 2^32.
REQ-028 Without RV_PERF_CNT_EN the ports and counters SHALL be absent.

Structure
REQ-029 State encodings, opcode constants, ALU_* codes and the PC4/PCIMM, ORIG_MEM/ALU/PC4 and ORIG_REG/IMM encodings SHALL live in the shared params package.
REQ-030 ALU-op decoding SHALL be a sub-module named alu_decoder (funct3, bit30, isRType -> ALU code).

Verification
REQ-031 Scenario: add x3,x1,x2 with no waits -> states 0,DECODE,EXEC_R,WB_ALU; oRegWrite=1 with ORIG_ALU in cycle 4; oRetire pulse; 4 cycles total.
REQ-032 Scenario: lw with iMemReady low for 3 cycles -> MEM_RD held 4 cycles with oMemRead=1; WB_MEM follows; 8 cycles total.
REQ-033 Scenario: beq with iEqual=1 and then with iEqual=0 -> oOrigPC=PCIMM, then PC4; oRegWrite=0 both times; 3 cycles each.
REQ-034 Scenario: opcode 1110011 -> HALT with oHalted=1 held for 10 cycles; reset then returns to FETCH.
REQ-035 Scenario: reset asserted during MEM_WR wait -> next state FETCH, oMemWrite=0, no oRetire; with RV_PERF_CNT_EN both counters read 0.
